vga_timing_out: RTL and testbench

- Upstream/downstream neighbour of the character-memory renderer. Generates 640x480@60 VGA timing from the system clock.
- Drives h_addr/v_addr into the renderer and accepts its 12-bit vga_data.
- Delays sync/blank by the renderer's read latency and drives aligned, blank-gated RGB and sync pins to the board connector.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_if.sv | 34 +++
 rtl/vga_sync_delay.sv | 36 +++
 rtl/vga_timing_out.sv | 139 +++++++++++++
 tb/tb_vga_timing_out.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and shared types
// for the VGA timing/output stage.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [11:0] rgb_t;

  typedef struct packed {
    logic act;
    logic hs_n;
    logic vs_n;
  } sync_bundle_t;

  localparam sync_bundle_t SYNC_IDLE = '{
    act:  1'b0,
    hs_n: 1'b1,
    vs_n: 1'b1
  };

endpackage

// File: rtl/vga_if.sv
// vga_if: renderer address/data bundle plus
// the board connector pins.
interface vga_if;
  import vga_pkg::*;

  logic [9:0] h_addr;
  logic [9:0] v_addr;
  logic       pix_tick;
  logic       frame_start;
  rgb_t       vga_data;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;

  modport master (
    output h_addr, v_addr,
    output pix_tick, frame_start,
    input  vga_data,
    output vga_hs, vga_vs, vga_blank_n,
    output vga_r, vga_g, vga_b
  );

  modport slave (
    input  h_addr, v_addr,
    input  pix_tick, frame_start,
    output vga_data,
    input  vga_hs, vga_vs, vga_blank_n,
    input  vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: PIPE-deep tick-enabled shift register
// that aligns sync/blank with the renderer read latency.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int PIPE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick,
  input  sync_bundle_t din,
  output sync_bundle_t tap
);

  if (PIPE == 0) begin : g_bypass
    logic unused;
    assign unused = &{1'b0, clock, reset, tick};
    assign tap = din;
  end else begin : g_pipe
    sync_bundle_t stg [PIPE];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < PIPE; i++)
          stg[i] <= SYNC_IDLE;
      end else if (tick) begin
        stg[0] <= din;
        for (int i = 1; i < PIPE; i++)
          stg[i] <= stg[i-1];
      end
    end

    assign tap = stg[PIPE-1];
  end

endmodule

// File: rtl/vga_timing_out.sv
// vga_timing_out: VGA timing generator, renderer address
// source and latency-aligned pin output stage.
module vga_timing_out #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int CLK_DIV  = 4,
  parameter int PIPE     = 1
) (
  input logic  clock,
  input logic  reset,
  vga_if.master bus
);
  import vga_pkg::*;

  localparam int HT =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_VIS = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE  =
    10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_END = 10'(HT - 1);
  localparam logic [9:0] V_VIS = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE  =
    10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_END = 10'(VT - 1);

  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_END = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          tick;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          started;
  logic          fs_q;
  logic          h_wrap;
  logic          v_wrap;
  sync_bundle_t  dec;
  sync_bundle_t  tap;
  logic          hs_q;
  logic          vs_q;
  logic          blank_q;
  rgb_t          rgb_q;

  assign div_nxt =
    (div_cnt == D_END) ? '0 : div_cnt + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      tick    <= (div_nxt == D_END);
    end
  end

  assign h_wrap = (h_cnt == H_END);
  assign v_wrap = (v_cnt == V_END);

  // The first tick only arms the raster so that pixel
  // (0,0) gets a full period and a frame_start pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      started <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      if (tick) begin
        if (!started) begin
          started <= 1'b1;
          fs_q    <= 1'b1;
        end else begin
          h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
          if (h_wrap)
            v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
          fs_q <= h_wrap && v_wrap;
        end
      end
    end
  end

  always_comb begin
    dec = SYNC_IDLE;
    if (started) begin
      dec.act  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      dec.hs_n = !((h_cnt >= H_SS) && (h_cnt < H_SE));
      dec.vs_n = !((v_cnt >= V_SS) && (v_cnt < V_SE));
    end
  end

  vga_sync_delay #(
    .PIPE(PIPE)
  ) u_delay (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .din   (dec),
    .tap   (tap)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else if (tick) begin
      hs_q    <= tap.hs_n;
      vs_q    <= tap.vs_n;
      blank_q <= tap.act;
      rgb_q   <= tap.act ? bus.vga_data : '0;
    end
  end

  assign bus.h_addr = (h_cnt < H_VIS) ? h_cnt : '0;
  assign bus.v_addr = (v_cnt < V_VIS) ? v_cnt : '0;
  assign bus.pix_tick    = tick;
  assign bus.frame_start = fs_q;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_blank_n = blank_q;
  assign {bus.vga_r, bus.vga_g, bus.vga_b} = rgb_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: directed checks of timing, latency,
// blanking and reset across four configurations.
module tb_vga_timing_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, rst_d;
  int checks = 0;
  int errors = 0;

  vga_if ia();
  vga_if ib();
  vga_if ic();
  vga_if id();

  vga_timing_out #(
    .CLK_DIV(4), .PIPE(1)
  ) dut_a (.clock(clk), .reset(rst_a), .bus(ia));

  vga_timing_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .PIPE(1)
  ) dut_b (.clock(clk), .reset(rst_b), .bus(ib));

  vga_timing_out #(
    .CLK_DIV(1), .PIPE(2)
  ) dut_c (.clock(clk), .reset(rst_c), .bus(ic));

  vga_timing_out #(
    .CLK_DIV(1), .PIPE(0)
  ) dut_d (.clock(clk), .reset(rst_d), .bus(id));

  // renderer stand-ins
  logic [11:0] lb1, lb2;
  always_ff @(posedge clk) begin
    if (!rst_c) begin
      lb1 <= '0;
      lb2 <= '0;
    end else if (ic.pix_tick) begin
      lb1 <= {2'b00, ic.h_addr};
      lb2 <= lb1;
    end
  end
  assign ic.vga_data = lb2;
  assign ib.vga_data = 12'h5A5;
  assign id.vga_data = {2'b00, id.h_addr};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  int sb_vs_lo, sb_vs_first, sb_bl, sb_hs, sb_rgb_bad;
  logic sb_bl52, sb_bl53;

  // Call at #1 after the frame_start edge of dut_b.
  task automatic scan_b();
    sb_vs_lo = 0; sb_vs_first = -1; sb_bl = 0;
    sb_hs = 0; sb_rgb_bad = 0;
    sb_bl52 = 1'bx; sb_bl53 = 1'bx;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 120; i++) begin
      if (!ib.vga_vs) begin
        sb_vs_lo++;
        if (sb_vs_first < 0) sb_vs_first = i;
      end
      if (!ib.vga_hs) sb_hs++;
      if (ib.vga_blank_n) sb_bl++;
      if ({ib.vga_r, ib.vga_g, ib.vga_b} !==
          (ib.vga_blank_n ? 12'h5A5 : 12'h000))
        sb_rgb_bad++;
      if (i == 52) sb_bl52 = ib.vga_blank_n;
      if (i == 53) sb_bl53 = ib.vga_blank_n;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  logic [11:0] pt_v, fs_v, hs_v, vs_v, bl_v;
  int bl_cnt, bl_early, rgb_bad, hs_cnt, hs_first;
  int vs_lo, addr_bad, n, got, col, pt0, t1, t2;
  logic [9:0] prev_h;
  logic prev_hs;
  logic [12:0] c0, c639;
  logic bl640;

  initial begin
    rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
    ia.vga_data = 12'hABC;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_hs", ia.vga_hs, 1);
    chk("rst_vs", ia.vga_vs, 1);
    chk("rst_blank", ia.vga_blank_n, 0);
    chk("rst_rgb", {ia.vga_r, ia.vga_g, ia.vga_b}, 0);
    chk("rst_tick_fs", {ia.pix_tick, ia.frame_start}, 0);
    chk("rst_addr", {ia.h_addr, ia.v_addr}, 0);

    // ---- A: default timing, CLK_DIV=4, PIPE=1
    @(negedge clk) rst_a = 1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      pt_v[k] = ia.pix_tick;
      fs_v[k] = ia.frame_start;
      hs_v[k] = ia.vga_hs;
      vs_v[k] = ia.vga_vs;
      bl_v[k] = ia.vga_blank_n;
    end
    chk("a_tick_pattern", pt_v, 12'h444);
    chk("a_fs_pattern", fs_v, 12'h008);
    chk("a_hs_idle", hs_v, 12'hFFF);
    chk("a_vs_idle", vs_v, 12'hFFF);
    chk("a_blank_start", bl_v, 12'h800);

    bl_cnt = 0; bl_early = 0; rgb_bad = 0; hs_cnt = 0;
    hs_first = -1; vs_lo = 0; addr_bad = 0;
    for (int i = 0; i < 800; i++) begin
      if (ia.vga_blank_n) begin
        bl_cnt++;
        if (i < 640) bl_early++;
      end
      if ({ia.vga_r, ia.vga_g, ia.vga_b} !==
          (ia.vga_blank_n ? 12'hABC : 12'h000))
        rgb_bad++;
      if (!ia.vga_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
      end
      if (!ia.vga_vs) vs_lo++;
      col = (i + 2) % 800;
      if (ia.h_addr !==
          ((col < 640) ? 10'(col) : 10'd0))
        addr_bad++;
      repeat (4) @(posedge clk);
      #1;
    end
    chk("a_blank_count", bl_cnt, 640);
    chk("a_blank_visible", bl_early, 640);
    chk("a_rgb_gate", rgb_bad, 0);
    chk("a_hs_width", hs_cnt, 96);
    chk("a_hs_start", hs_first, 656);
    chk("a_vs_line0", vs_lo, 0);
    chk("a_h_addr", addr_bad, 0);
    chk("a_next_line", {ia.v_addr, ia.h_addr},
        {10'd1, 10'd2});

    // ---- B: small raster, full frames
    @(negedge clk) rst_b = 1;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (ib.frame_start) begin got = 1; break; end
    end
    chk("b_fs_first", got, 1);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (ib.frame_start) break;
    end
    chk("b_frame_clocks", n, 240);
    chk("b_fs_origin", {ib.h_addr, ib.v_addr}, 0);
    scan_b();
    chk("b_vs_width", sb_vs_lo, 30);
    chk("b_vs_start", sb_vs_first, 75);
    chk("b_hs_total", sb_hs, 24);
    chk("b_blank_total", sb_bl, 32);
    chk("b_last_pixel", {sb_bl52, sb_bl53}, 2'b10);
    chk("b_rgb_gate", sb_rgb_bad, 0);

    got = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      #1;
      if (ib.frame_start) begin got = 1; break; end
    end
    chk("b_fs_again", got, 1);
    repeat (174) @(posedge clk);
    #1;
    chk("b_pre_rst_sync", {ib.vga_hs, ib.vga_vs}, 0);
    #1 rst_b = 0;
    #1;
    chk("b_async_sync", {ib.vga_hs, ib.vga_vs}, 2'b11);
    chk("b_async_blank", ib.vga_blank_n, 0);
    chk("b_async_rgb", {ib.vga_r, ib.vga_g, ib.vga_b}, 0);
    chk("b_async_ctl", {ib.pix_tick, ib.frame_start}, 0);
    chk("b_async_addr", {ib.h_addr, ib.v_addr}, 0);
    @(negedge clk) rst_b = 1;
    got = 0; vs_lo = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (!ib.vga_vs) vs_lo++;
      if (ib.frame_start) begin got = 1; break; end
    end
    chk("b_fs_after_rst", got, 1);
    chk("b_no_partial_vs", vs_lo, 0);
    scan_b();
    chk("b_vs_start_rst", sb_vs_first, 75);

    // ---- C: loopback, CLK_DIV=1, PIPE=2
    @(negedge clk) rst_c = 1;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (ic.frame_start) begin got = 1; break; end
    end
    chk("c_fs_first", got, 1);
    repeat (3) @(posedge clk);
    #1;
    rgb_bad = 0; bl_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (ic.vga_blank_n !== (i < 640)) rgb_bad++;
      if (ic.vga_blank_n) bl_cnt++;
      if ({ic.vga_r, ic.vga_g, ic.vga_b} !==
          ((i < 640) ? 12'(i) : 12'h000))
        rgb_bad++;
      if (i == 0)
        c0 = {ic.vga_blank_n, ic.vga_r, ic.vga_g, ic.vga_b};
      if (i == 639)
        c639 = {ic.vga_blank_n, ic.vga_r, ic.vga_g, ic.vga_b};
      if (i == 640) bl640 = ic.vga_blank_n;
      @(posedge clk);
      #1;
    end
    chk("c_loopback", rgb_bad, 0);
    chk("c_blank_count", bl_cnt, 640);
    chk("c_col0", c0, 13'h1000);
    chk("c_col639", c639, 13'h127F);
    chk("c_col640", bl640, 0);

    // ---- D: CLK_DIV=1, PIPE=0
    @(negedge clk) rst_d = 1;
    prev_h = '0; prev_hs = 1'b1;
    pt0 = 0; rgb_bad = 0; t1 = -1; t2 = -1;
    for (int k = 0; k < 1700; k++) begin
      @(posedge clk);
      #1;
      if (!id.pix_tick) pt0++;
      if ({id.vga_r, id.vga_g, id.vga_b} !==
          {2'b00, prev_h})
        rgb_bad++;
      prev_h = id.h_addr;
      if (prev_hs && !id.vga_hs) begin
        if (t1 < 0) t1 = k;
        else if (t2 < 0) t2 = k;
      end
      prev_hs = id.vga_hs;
    end
    chk("d_tick_const", pt0, 0);
    chk("d_rgb_lag", rgb_bad, 0);
    chk("d_hs_seen", (t1 >= 0) && (t2 >= 0), 1);
    chk("d_line_clocks", t2 - t1, 800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
